// File: rtl/fuzzy_output_bank_pkg.sv
// Shared types and defaults for the fuzzy output-membership bank.
// Related build option: FUZZY_OUT_AGG_MAX_EN selects max aggregation in the top.
package fuzzy_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_RULE_W = 4;
    localparam int unsigned DEF_N_OUT  = 3;

    // LSB position of channel k inside the flat sat_bus vector
    function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/fuzzy_output_bank_if.sv
// Beat / frame / result signal bundle between inference stage, bank and defuzzifier.
interface fuzzy_output_bank_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RULE_W = 4,
    parameter int unsigned N_OUT  = 3,
    parameter int unsigned CNT_W  = RULE_W + 1
);
    logic                    frame_start;
    logic                    frame_end;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [RULE_W-1:0]       in_rule;
    logic                    out_valid;
    logic                    out_ack;
    logic [N_OUT*DATA_W-1:0] sat_bus;
    logic [CNT_W-1:0]        rule_cnt;
    logic                    err;

    modport master (
        output frame_start, frame_end, in_valid, in_data, in_rule, out_ack,
        input  in_ready, out_valid, sat_bus, rule_cnt, err
    );

    modport slave (
        input  frame_start, frame_end, in_valid, in_data, in_rule, out_ack,
        output in_ready, out_valid, sat_bus, rule_cnt, err
    );
endinterface

// File: rtl/fuzzy_output_bank_rule_decoder.sv
// Combinational rule-code decoder: one-hot channel enable plus in-range flag.
module rule_decoder #(
    parameter int unsigned RULE_W = 4,
    parameter int unsigned N_OUT  = 3
) (
    input  logic [RULE_W-1:0] in_rule,
    output logic [N_OUT-1:0]  en,
    output logic              in_range
);

    // Codes at or beyond N_OUT enable no channel
    always_comb begin
        en       = '0;
        in_range = (32'(in_rule) < N_OUT);
        for (int unsigned k = 0; k < N_OUT; k++) begin
            en[k] = (32'(in_rule) == k);
        end
    end

endmodule

// File: rtl/fuzzy_output_bank.sv
// Output-membership register bank: per-channel aggregation over one inference
// frame, result held under a valid/ack handshake.
// Build option: FUZZY_OUT_AGG_MAX_EN -> fuzzy OR (max); undefined -> last write wins.
module fuzzy_output_bank
    import fuzzy_out_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RULE_W = DEF_RULE_W,
    parameter int unsigned N_OUT  = DEF_N_OUT,
    parameter int unsigned CNT_W  = RULE_W + 1
) (
    input logic                clk,
    input logic                rst,
    fuzzy_output_bank_if.slave bus
);

    state_t                  state_q, state_d;
    logic [N_OUT*DATA_W-1:0] sat_q, sat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [N_OUT-1:0]        chan_en;
    logic                    in_range;

    rule_decoder #(
        .RULE_W (RULE_W),
        .N_OUT  (N_OUT)
    ) u_dec (
        .in_rule  (bus.in_rule),
        .en       (chan_en),
        .in_range (in_range)
    );

    // State and result registers; reset clears everything including a partial frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sat_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, beat steering and aggregation; frame_start dominates every other event
    always_comb begin
        state_d = state_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    sat_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.frame_start) begin
                    sat_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                end else begin
                    if (bus.in_valid) begin
                        for (int unsigned k = 0; k < N_OUT; k++) begin
                            if (chan_en[k]) begin
`ifdef FUZZY_OUT_AGG_MAX_EN
                                if (bus.in_data > sat_q[chan_lsb(k, DATA_W) +: DATA_W])
                                    sat_d[chan_lsb(k, DATA_W) +: DATA_W] = bus.in_data;
`else
                                sat_d[chan_lsb(k, DATA_W) +: DATA_W] = bus.in_data;
`endif
                            end
                        end
                        if (!in_range)
                            err_d = 1'b1;
                        if (cnt_q != '1)
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (bus.frame_end)
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.frame_start) begin
                    sat_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end else if (bus.out_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.sat_bus   = sat_q;
    assign bus.rule_cnt  = cnt_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_fuzzy_output_bank.sv
// Directed bench for fuzzy_output_bank (N_OUT=3, DATA_W=8, CNT_W=4).
module tb_fuzzy_output_bank;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fuzzy_output_bank_if #(
        .DATA_W (8),
        .RULE_W (4),
        .N_OUT  (3),
        .CNT_W  (4)
    ) bus_if ();

    fuzzy_output_bank #(
        .DATA_W (8),
        .RULE_W (4),
        .N_OUT  (3),
        .CNT_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] rule, input logic [7:0] data);
        bus_if.in_valid = 1'b1;
        bus_if.in_rule  = rule;
        bus_if.in_data  = data;
        step();
        bus_if.in_valid = 1'b0;
    endtask

    logic [23:0] exp_main;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus_if.frame_start = 1'b0;
        bus_if.frame_end   = 1'b0;
        bus_if.in_valid    = 1'b0;
        bus_if.in_data     = '0;
        bus_if.in_rule     = '0;
        bus_if.out_ack     = 1'b0;
`ifdef FUZZY_OUT_AGG_MAX_EN
        exp_main = 24'h110090;
`else
        exp_main = 24'h110020;
`endif
        #3;
        check("rst_ready", 32'(bus_if.in_ready), 32'd0);
        check("rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_sat",   32'(bus_if.sat_bus), 32'd0);
        check("rst_cnt",   32'(bus_if.rule_cnt), 32'd0);
        check("rst_err",   32'(bus_if.err), 32'd0);
        #9 rst = 1'b1;

        // Reset in the middle of a frame
        bus_if.frame_start = 1'b1;
        step();
        bus_if.frame_start = 1'b0;
        check("accum_ready", 32'(bus_if.in_ready), 32'd1);
        beat(4'd1, 8'h33);
        beat(4'd2, 8'h44);
        check("mid_sat", 32'(bus_if.sat_bus), 32'h443300);
        check("mid_cnt", 32'(bus_if.rule_cnt), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_sat",   32'(bus_if.sat_bus), 32'd0);
        check("arst_cnt",   32'(bus_if.rule_cnt), 32'd0);
        check("arst_ready", 32'(bus_if.in_ready), 32'd0);
        rst = 1'b1;

        // Main aggregation frame
        bus_if.frame_start = 1'b1;
        step();
        bus_if.frame_start = 1'b0;
        beat(4'd0, 8'h40);
        check("lat_sat", 32'(bus_if.sat_bus), 32'h000040);
        beat(4'd0, 8'h90);
        beat(4'd0, 8'h20);
        beat(4'd2, 8'h11);
        bus_if.frame_end = 1'b1;
        step();
        bus_if.frame_end = 1'b0;
        check("main_valid", 32'(bus_if.out_valid), 32'd1);
        check("main_ready", 32'(bus_if.in_ready), 32'd0);
        check("main_sat",   32'(bus_if.sat_bus), 32'(exp_main));
        check("main_cnt",   32'(bus_if.rule_cnt), 32'd4);
        check("main_err",   32'(bus_if.err), 32'd0);
        bus_if.out_ack = 1'b1;
        step();
        bus_if.out_ack = 1'b0;
        check("ack_valid", 32'(bus_if.out_valid), 32'd0);
        check("ack_sat",   32'(bus_if.sat_bus), 32'(exp_main));

        // IDLE ignores beats and frame_end
        bus_if.frame_end = 1'b1;
        beat(4'd1, 8'hEE);
        bus_if.frame_end = 1'b0;
        check("idle_valid", 32'(bus_if.out_valid), 32'd0);
        check("idle_sat",   32'(bus_if.sat_bus), 32'(exp_main));
        check("idle_cnt",   32'(bus_if.rule_cnt), 32'd4);

        // Out-of-range code, then beat coinciding with frame_end
        bus_if.frame_start = 1'b1;
        step();
        bus_if.frame_start = 1'b0;
        check("clr_sat", 32'(bus_if.sat_bus), 32'd0);
        beat(4'd5, 8'hAA);
        check("oor_err", 32'(bus_if.err), 32'd1);
        check("oor_cnt", 32'(bus_if.rule_cnt), 32'd1);
        check("oor_sat", 32'(bus_if.sat_bus), 32'd0);
        bus_if.frame_end = 1'b1;
        beat(4'd1, 8'h7F);
        bus_if.frame_end = 1'b0;
        check("fe_valid", 32'(bus_if.out_valid), 32'd1);
        check("fe_sat",   32'(bus_if.sat_bus), 32'h007F00);
        check("fe_cnt",   32'(bus_if.rule_cnt), 32'd2);

        // HOLD freezes results against persistent beats
        bus_if.in_valid = 1'b1;
        bus_if.in_rule  = 4'd0;
        bus_if.in_data  = 8'hFF;
        for (int i = 0; i < 5; i++) step();
        check("hold_sat",   32'(bus_if.sat_bus), 32'h007F00);
        check("hold_ready", 32'(bus_if.in_ready), 32'd0);
        check("hold_cnt",   32'(bus_if.rule_cnt), 32'd2);
        check("hold_err",   32'(bus_if.err), 32'd1);
        bus_if.in_valid = 1'b0;

        // frame_start in HOLD beats same-cycle ack and clears err
        bus_if.frame_start = 1'b1;
        bus_if.out_ack     = 1'b1;
        step();
        bus_if.frame_start = 1'b0;
        bus_if.out_ack     = 1'b0;
        check("restart_ready", 32'(bus_if.in_ready), 32'd1);
        check("restart_err",   32'(bus_if.err), 32'd0);

        // Restart in ACCUM discards same-cycle beat and frame_end
        beat(4'd0, 8'h12);
        bus_if.frame_start = 1'b1;
        bus_if.frame_end   = 1'b1;
        beat(4'd1, 8'h7F);
        bus_if.frame_start = 1'b0;
        bus_if.frame_end   = 1'b0;
        check("fs_sat",   32'(bus_if.sat_bus), 32'd0);
        check("fs_cnt",   32'(bus_if.rule_cnt), 32'd0);
        check("fs_valid", 32'(bus_if.out_valid), 32'd0);
        check("fs_ready", 32'(bus_if.in_ready), 32'd1);

        // Counter saturation with 20 back-to-back beats
        for (int i = 0; i < 20; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_rule  = 4'(i % 3);
            bus_if.in_data  = 8'(i + 1);
            step();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.frame_end = 1'b1;
        step();
        bus_if.frame_end = 1'b0;
        check("sat_cnt", 32'(bus_if.rule_cnt), 32'd15);
        check("sat_bus", 32'(bus_if.sat_bus), 32'h121413);
        check("sat_valid", 32'(bus_if.out_valid), 32'd1);
        bus_if.out_ack = 1'b1;
        step();
        bus_if.out_ack = 1'b0;
        check("end_valid", 32'(bus_if.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
